// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment display driver.
//   - Active-low 7-bit segment patterns for hex digits 0..F, bit order g..a
//     (bit 0 = segment a), plus an all-segments-off pattern.
//   - Active-low anode all-off pattern.
package ssd_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/hex_to_seven_seg.sv
// hex_to_seven_seg: combinational 4-bit hex to active-low 7-segment decoder.
// Ports:
//   hex  [3:0]  input   hex digit value
//   seg  [6:0]  output  active-low segments, bit order g..a
module hex_to_seven_seg
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_4.sv
// seven_segment_4: time-multiplexed driver for a 4-digit common-anode
// seven-segment display showing a 16-bit hex value.
// Parameters:
//   CLK_FREQUENCY  input clock frequency in Hz
//   REFRESH_RATE   full 4-digit refresh rate in Hz
//   Each digit is lit for CLK_FREQUENCY/REFRESH_RATE/4 cycles (must be >= 2).
// Ports:
//   clk      input        system clock, rising edge
//   rst      input        asynchronous reset, active-low
//   data_in  input  [15:0] four hex digits, digit 0 = data_in[3:0] (rightmost)
//   blank    input  [3:0]  blank[i]=1 turns digit i fully off
//   dp_in    input  [3:0]  dp_in[i]=1 lights decimal point of digit i
//   segment  output [7:0]  active-low cathodes, [6:0]=g..a, [7]=DP
//   anode    output [3:0]  active-low digit enables
// Build option:
//   SSD_LEADING_ZERO_BLANK_EN  when defined, leading zero digits (3..1) are
//                              also blanked; digit 0 is always shown.
module seven_segment_4
    import ssd_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned REFRESH_RATE  = 200
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp_in,
    output logic [7:0]  segment,
    output logic [3:0]  anode
);

    localparam int unsigned SEGMENT_CLOCKS = CLK_FREQUENCY / REFRESH_RATE / 4;
    localparam int unsigned CNT_W          = $clog2(SEGMENT_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SEGMENT_CLOCKS - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       index;
    logic [3:0]       digit;
    logic [6:0]       seg_digit;
    logic [3:0]       blank_eff;

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            index <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            index <= index + 2'd1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [3:0] lz_blank;

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        lz_blank    = '0;
        lz_blank[3] = (data_in[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (data_in[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (data_in[7:4]  == 4'h0);
    end

    assign blank_eff = blank | lz_blank;
`else
    assign blank_eff = blank;
`endif

    assign digit = data_in[{index, 2'b00} +: 4];

    hex_to_seven_seg u_dec (
        .hex (digit),
        .seg (seg_digit)
    );

    // Outputs are forced dark while reset is held, independent of the clock.
    always_comb begin
        anode   = ANODE_OFF;
        segment = {1'b1, SEG_OFF};
        if (rst && !blank_eff[index]) begin
            anode   = ~(4'b0001 << index);
            segment = {~dp_in[index], seg_digit};
        end
    end

endmodule

// File: tb/tb_seven_segment_4.sv
// tb_seven_segment_4: directed self-checking bench for seven_segment_4,
// configured for 50 clocks per digit slot.
module tb_seven_segment_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  blank;
    logic [3:0]  dp_in;
    logic [7:0]  segment;
    logic [3:0]  anode;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    seven_segment_4 #(
        .CLK_FREQUENCY (100_000_000),
        .REFRESH_RATE  (500_000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .blank   (blank),
        .dp_in   (dp_in),
        .segment (segment),
        .anode   (anode)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        data_in = d;
        blank   = b;
        dp_in   = p;
        #1;
    endtask

    task automatic chk(input string tag, input int d, input logic [3:0] ea, input logic [7:0] es);
        vectors++;
        assert ({anode, segment} === {ea, es}) else begin
            miscompares++;
            $error("FAIL %s digit%0d: anode=%b segment=%b, expected anode=%b segment=%b",
                   tag, d, anode, segment, ea, es);
        end
        vectors++;
        assert ($countones(~anode) <= 1) else begin
            miscompares++;
            $error("FAIL %s digit%0d onehot: anode=%b, expected at most one low bit",
                   tag, d, anode);
        end
    endtask

    // Check n consecutive cycles of one digit slot, advancing a cycle after each.
    task automatic run_digit(input string tag, input int d, input int n,
                             input logic [3:0] ea, input logic [7:0] es);
        for (int i = 0; i < n; i++) begin
            chk(tag, d, ea, es);
            tick();
        end
    endtask

    task automatic scan(input string tag,
                        input logic [3:0] a0, input logic [7:0] s0,
                        input logic [3:0] a1, input logic [7:0] s1,
                        input logic [3:0] a2, input logic [7:0] s2,
                        input logic [3:0] a3, input logic [7:0] s3);
        run_digit(tag, 0, 50, a0, s0);
        run_digit(tag, 1, 50, a1, s1);
        run_digit(tag, 2, 50, a2, s2);
        run_digit(tag, 3, 50, a3, s3);
    endtask

    initial begin
        int n;

        // Reset asserted: outputs dark regardless of inputs
        rst = 1'b0;
        apply(16'h0123, 4'b0000, 4'b0001);
        tick();
        tick();
        tick();
        chk("reset", 0, 4'b1111, 8'hFF);

        // Release at posedge+1; the sample that follows is the first cycle of digit 0
        rst = 1'b1;
        #1;
        scan("d0123",
             4'b1110, 8'h30, 4'b1101, 8'hA4, 4'b1011, 8'hF9, 4'b0111, 8'hC0);

        apply(16'hCDEF, 4'b0000, 4'b1000);
        scan("dcdef",
             4'b1110, 8'h8E, 4'b1101, 8'h86, 4'b1011, 8'hA1, 4'b0111, 8'h46);

        apply(16'h1234, 4'b0001, 4'b1111);
        scan("blank0001",
             4'b1111, 8'hFF, 4'b1101, 8'h30, 4'b1011, 8'h24, 4'b0111, 8'h79);

        apply(16'h1234, 4'b0010, 4'b1111);
        scan("blank0010",
             4'b1110, 8'h19, 4'b1111, 8'hFF, 4'b1011, 8'h24, 4'b0111, 8'h79);

        apply(16'h1234, 4'b0100, 4'b1111);
        scan("blank0100",
             4'b1110, 8'h19, 4'b1101, 8'h30, 4'b1111, 8'hFF, 4'b0111, 8'h79);

        apply(16'h1234, 4'b1000, 4'b1111);
        scan("blank1000",
             4'b1110, 8'h19, 4'b1101, 8'h30, 4'b1011, 8'h24, 4'b1111, 8'hFF);

        // All blanked for 151 cycles: ends one cycle into the digit 3 slot
        apply(16'h1234, 4'b1111, 4'b1111);
        run_digit("blank1111", 0, 151, 4'b1111, 8'hFF);

        apply(16'h2345, 4'b0000, 4'b0101);
        run_digit("d2345_tail", 3, 49, 4'b0111, 8'hA4);
        scan("d2345",
             4'b1110, 8'h12, 4'b1101, 8'h99, 4'b1011, 8'h30, 4'b0111, 8'hA4);

        // Reset in the middle of the digit 2 slot
        run_digit("pre_rst", 0, 50, 4'b1110, 8'h12);
        run_digit("pre_rst", 1, 50, 4'b1101, 8'h99);
        run_digit("pre_rst", 2, 20, 4'b1011, 8'h30);
        rst = 1'b0;
        #1;
        chk("rst_async", 2, 4'b1111, 8'hFF);
        tick();
        tick();
        chk("rst_hold", 2, 4'b1111, 8'hFF);
        rst = 1'b1;
        #1;

        n = 0;
        while (anode == 4'b1110 && n < 200) begin
            n++;
            tick();
        end
        vectors++;
        assert (n === 50) else begin
            miscompares++;
            $error("FAIL rst_slot_len: digit0 lasted %0d cycles, expected 50", n);
        end
        chk("post_rst", 1, 4'b1101, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
